mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port data memory between instruction fetch (read-only) and the data-memory stage (load/store with byte mask).
- Grants at most one access per cycle and tracks in-flight reads through a fixed-latency tag pipeline.
- Returns read data to the requester that issued the read.
- Starvation counter guarantees fetch forward progress under back-to-back load/store traffic.

Parameters:
- AW, 32, address width (matches `MEM_ADDR_BUS`).
- DW, 32, data width (matches `MEM_DATA_BUS`).
- MW, 4, write-mask width (DW/8).
- RD_LAT, 1, memory read latency in cycles, legal 1..4.
- MAX_WAIT, 3, consecutive cycles fetch may be denied before it is forced priority, legal 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch read request.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DW  fetch read data.
- dm_req  in  1  data request.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_wmask  in  MW  store byte mask.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  load data valid.
- dm_rdata  out  DW  load data.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write enable.
- mem_a  out  AW  memory address.
- mem_wd  out  DW  memory write data.
- mem_wmask  out  MW  memory write mask.
- mem_rd  in  DW  memory read data, valid RD_LAT cycles after a read with mem_en=1.

Behaviour:
- Reset (rst_n low, async):
  - Priority FSM to DM_PRIO.
  - wait_cnt = 0.
  - Tag pipeline cleared, so all rvalid = 0.
  - if_gnt, dm_gnt, mem_en, mem_we = 0 and mem_wmask = 0 while rst_n is low, regardless of requests.
- Grant is combinational in the request cycle; requesters hold req/addr/data stable until they see gnt.
- FSM states:
  - DM_PRIO: dm_req wins whenever asserted; if_req is granted only when dm_req = 0.
  - IF_PRIO: if_req wins; dm_req is granted only when if_req = 0.
- Transitions:
  - DM_PRIO -> IF_PRIO when a cycle ends with if_req=1, if_gnt=0 and wait_cnt == MAX_WAIT-1.
  - IF_PRIO -> DM_PRIO on the cycle if_gnt=1.
- wait_cnt:
  - Increments on each cycle with if_req=1 and if_gnt=0.
  - Clears on if_gnt or when if_req=0.
  - Saturates at MAX_WAIT.
- Memory drive:
  - mem_en = if_gnt | dm_gnt; mem_a = winner address.
  - mem_we = dm_gnt & dm_we; mem_wd = dm_wdata.
  - mem_wmask = dm_wmask when mem_we=1, else 0.
- Tag pipeline:
  - RD_LAT-deep shift register of {valid, owner}; a granted read pushes {1, IF|DM}, writes push {0,-}.
  - At the tail: if_rvalid = valid & owner==IF, dm_rvalid = valid & owner==DM.
  - if_rdata and dm_rdata both = mem_rd, qualified only by their rvalid.
- Throughput: one access per cycle, no bubbles; back-to-back reads from either side return in order.
- Store response: none; dm_gnt is completion from the requester's view.
- Simultaneous requests:
  - DM_PRIO: dm_gnt=1, if_gnt=0.
  - IF_PRIO: if_gnt=1, dm_gnt=0.
- No request: mem_en=0, and a {0,-} bubble is pushed into the tag pipeline.
- Reset mid-operation: in-flight reads are discarded (no rvalid after reset release); the memory may still complete them harmlessly.

Optional Feature:
- Macro MEMARB_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_conflict[31:0]: counts cycles with if_req & dm_req.
  - perf_forced[31:0]: counts IF_PRIO entries.
- Both counters wrap at 2^32 and reset to 0.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single fetch read, RD_LAT=1, if_addr=0x100, mem_rd returns 0xDEADBEEF -> if_gnt=1 in cycle 0, if_rvalid=1 with if_rdata=0xDEADBEEF in cycle 1, dm_rvalid stays 0.
- Store, dm_we=1, dm_addr=0x20, dm_wmask=4'b0011 -> mem_en=1, mem_we=1, mem_wmask=0011, mem_wd=dm_wdata in the same cycle; no rvalid afterwards.
- Continuous dm loads with if_req held, MAX_WAIT=3 -> dm granted cycles 0-2, if_gnt=1 in cycle 3, dm granted again from cycle 4.
- RD_LAT=3, interleaved IF read, DM read, IF read on consecutive cycles -> rvalid in cycles 3/4/5 routed IF/DM/IF with matching data.
- rst_n pulled low one cycle after a load grant with RD_LAT=2 -> all outputs 0 immediately; no dm_rvalid after release.
- With MEMARB_PERF_CNT_EN: 10 cycles of both requests, MAX_WAIT=3 -> perf_conflict=10, perf_forced=2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port data memory between instruction fetch (read-only)
// and the data-memory stage (load/store with byte mask). At most one access
// is granted per cycle. Grants are combinational in the request cycle. A
// fixed-latency tag pipeline remembers who issued each read so that the
// returning data is flagged valid for the right requester.
//
// The data side has priority by default. Fetch is counted while it is
// denied; after MAX_WAIT consecutive denied cycles the arbiter switches to
// fetch priority until fetch is granted once. This guarantees fetch forward
// progress under back-to-back load/store traffic.
//
// Parameters:
//   AW        address width
//   DW        data width
//   MW        write-mask width (DW/8)
//   RD_LAT    memory read latency in cycles (1..4)
//   MAX_WAIT  denied fetch cycles before fetch is forced priority (1..15)
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   if_req/if_addr          fetch read request and address
//   if_gnt                  fetch request accepted this cycle
//   if_rvalid/if_rdata      fetch read data return
//   dm_req/dm_we/dm_addr    data request, 1 = store, address
//   dm_wdata/dm_wmask       store data and byte mask
//   dm_gnt                  data request accepted this cycle
//   dm_rvalid/dm_rdata      load data return
//   mem_en/mem_we/mem_a     memory enable, write enable, address
//   mem_wd/mem_wmask        memory write data and byte mask
//   mem_rd                  memory read data, RD_LAT cycles after a read
//
// Optional build macro MEMARB_PERF_CNT_EN adds:
//   perf_conflict[31:0]     cycles with both fetch and data requesting
//   perf_forced[31:0]       number of entries into fetch priority
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MW       = 4,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  // instruction fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  // data-memory stage port
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  input  logic [MW-1:0] dm_wmask,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  // memory port
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic [MW-1:0] mem_wmask,
  input  logic [DW-1:0] mem_rd
`ifdef MEMARB_PERF_CNT_EN
  ,
  output logic [31:0]   perf_conflict,
  output logic [31:0]   perf_forced
`endif
);

  typedef enum logic [0:0] {
    DM_PRIO = 1'b0,
    IF_PRIO = 1'b1
  } prio_e;

  localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  prio_e             r_state;
  prio_e             w_state_nxt;
  logic [3:0]        r_wait_cnt;
  logic [3:0]        w_wait_nxt;

  logic              w_if_win;
  logic              w_dm_win;
  logic              w_if_starved;

  // Tag pipeline: valid bit and owner bit (1 = fetch, 0 = data).
  logic [RD_LAT-1:0] r_tag_v;
  logic [RD_LAT-1:0] r_tag_o;
  logic [RD_LAT:0]   w_tag_v_ext;
  logic [RD_LAT:0]   w_tag_o_ext;
  logic              w_push_v;
  logic              w_push_o;

  // -------------------------------------------------------------------------
  // Grant selection. Both grants are forced low while reset is asserted so
  // that no memory access can be issued during reset.
  // -------------------------------------------------------------------------
  always_comb begin
    w_if_win = 1'b0;
    w_dm_win = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        DM_PRIO: begin
          w_dm_win = dm_req;
          w_if_win = if_req & ~dm_req;
        end
        IF_PRIO: begin
          w_if_win = if_req;
          w_dm_win = dm_req & ~if_req;
        end
        default: begin
          w_if_win = 1'b0;
          w_dm_win = 1'b0;
        end
      endcase
    end
  end

  assign if_gnt       = w_if_win;
  assign dm_gnt       = w_dm_win;
  assign w_if_starved = if_req & ~w_if_win;

  // -------------------------------------------------------------------------
  // Starvation counter and priority FSM
  // -------------------------------------------------------------------------
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!w_if_starved) begin
      w_wait_nxt = '0;
    end else if (r_wait_cnt < WAIT_MAX) begin
      w_wait_nxt = r_wait_cnt + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      DM_PRIO: begin
        if (w_if_starved && (r_wait_cnt == WAIT_LAST)) begin
          w_state_nxt = IF_PRIO;
        end
      end
      IF_PRIO: begin
        if (w_if_win) begin
          w_state_nxt = DM_PRIO;
        end
      end
      default: w_state_nxt = DM_PRIO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= DM_PRIO;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Memory drive
  // -------------------------------------------------------------------------
  always_comb begin
    mem_a = '0;
    if (w_if_win) begin
      mem_a = if_addr;
    end else if (w_dm_win) begin
      mem_a = dm_addr;
    end
  end

  assign mem_en    = w_if_win | w_dm_win;
  assign mem_we    = w_dm_win & dm_we;
  assign mem_wd    = dm_wdata;
  assign mem_wmask = mem_we ? dm_wmask : '0;

  // -------------------------------------------------------------------------
  // Tag pipeline. Every cycle pushes one entry (a bubble when there is no
  // read), so the tail always lines up with the memory's read latency.
  // The extended vectors make the shift work for RD_LAT = 1 as well.
  // -------------------------------------------------------------------------
  assign w_push_v    = w_if_win | (w_dm_win & ~dm_we);
  assign w_push_o    = w_if_win;
  assign w_tag_v_ext = {r_tag_v, w_push_v};
  assign w_tag_o_ext = {r_tag_o, w_push_o};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v <= '0;
      r_tag_o <= '0;
    end else begin
      r_tag_v <= w_tag_v_ext[RD_LAT-1:0];
      r_tag_o <= w_tag_o_ext[RD_LAT-1:0];
    end
  end

  assign if_rvalid = r_tag_v[RD_LAT-1] &  r_tag_o[RD_LAT-1];
  assign dm_rvalid = r_tag_v[RD_LAT-1] & ~r_tag_o[RD_LAT-1];
  assign if_rdata  = mem_rd;
  assign dm_rdata  = mem_rd;

`ifdef MEMARB_PERF_CNT_EN
  // -------------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32)
  // -------------------------------------------------------------------------
  logic [31:0] r_perf_conflict;
  logic [31:0] r_perf_forced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_conflict <= '0;
      r_perf_forced   <= '0;
    end else begin
      if (if_req && dm_req) begin
        r_perf_conflict <= r_perf_conflict + 32'd1;
      end
      if ((r_state == DM_PRIO) && (w_state_nxt == IF_PRIO)) begin
        r_perf_forced <= r_perf_forced + 32'd1;
      end
    end
  end

  assign perf_conflict = r_perf_conflict;
  assign perf_forced   = r_perf_forced;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. Three instances share one set of
// request inputs and one reset: u1 (RD_LAT=1), u2 (RD_LAT=2), u3 (RD_LAT=3),
// all with MAX_WAIT=3. Each instance gets its own behavioural memory whose
// read data is a fixed function of the address, delayed by RD_LAT cycles.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wmask;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Memory content: one special word, everything else derived from address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- u1: RD_LAT = 1 ----------------
  logic        a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid;
  logic        a_mem_en, a_mem_we;
  logic [31:0] a_if_rdata, a_dm_rdata, a_mem_a, a_mem_wd, a_mem_rd;
  logic [3:0]  a_mem_wmask;
  logic [31:0] a_pipe;
`ifdef MEMARB_PERF_CNT_EN
  logic [31:0] a_perf_conflict, a_perf_forced;
`endif

  mem_port_arbiter #(.AW(32), .DW(32), .MW(4), .RD_LAT(1), .MAX_WAIT(3)) u1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wmask(dm_wmask), .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid),
    .dm_rdata(a_dm_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_a(a_mem_a), .mem_wd(a_mem_wd),
    .mem_wmask(a_mem_wmask), .mem_rd(a_mem_rd)
`ifdef MEMARB_PERF_CNT_EN
    , .perf_conflict(a_perf_conflict), .perf_forced(a_perf_forced)
`endif
  );

  always @(posedge clk) a_pipe <= mem_f(a_mem_a);
  assign a_mem_rd = a_pipe;

  // ---------------- u2: RD_LAT = 2 ----------------
  logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_a, b_mem_wd, b_mem_rd;
  logic [3:0]  b_mem_wmask;
  logic [31:0] b_pipe [2];
`ifdef MEMARB_PERF_CNT_EN
  logic [31:0] b_perf_conflict, b_perf_forced;
`endif

  mem_port_arbiter #(.AW(32), .DW(32), .MW(4), .RD_LAT(2), .MAX_WAIT(3)) u2 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wmask(dm_wmask), .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid),
    .dm_rdata(b_dm_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_a(b_mem_a), .mem_wd(b_mem_wd),
    .mem_wmask(b_mem_wmask), .mem_rd(b_mem_rd)
`ifdef MEMARB_PERF_CNT_EN
    , .perf_conflict(b_perf_conflict), .perf_forced(b_perf_forced)
`endif
  );

  always @(posedge clk) begin
    b_pipe[0] <= mem_f(b_mem_a);
    b_pipe[1] <= b_pipe[0];
  end
  assign b_mem_rd = b_pipe[1];

  // ---------------- u3: RD_LAT = 3 ----------------
  logic        c_if_gnt, c_if_rvalid, c_dm_gnt, c_dm_rvalid;
  logic        c_mem_en, c_mem_we;
  logic [31:0] c_if_rdata, c_dm_rdata, c_mem_a, c_mem_wd, c_mem_rd;
  logic [3:0]  c_mem_wmask;
  logic [31:0] c_pipe [3];
`ifdef MEMARB_PERF_CNT_EN
  logic [31:0] c_perf_conflict, c_perf_forced;
`endif

  mem_port_arbiter #(.AW(32), .DW(32), .MW(4), .RD_LAT(3), .MAX_WAIT(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(c_if_gnt),
    .if_rvalid(c_if_rvalid), .if_rdata(c_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wmask(dm_wmask), .dm_gnt(c_dm_gnt), .dm_rvalid(c_dm_rvalid),
    .dm_rdata(c_dm_rdata),
    .mem_en(c_mem_en), .mem_we(c_mem_we), .mem_a(c_mem_a), .mem_wd(c_mem_wd),
    .mem_wmask(c_mem_wmask), .mem_rd(c_mem_rd)
`ifdef MEMARB_PERF_CNT_EN
    , .perf_conflict(c_perf_conflict), .perf_forced(c_perf_forced)
`endif
  );

  always @(posedge clk) begin
    c_pipe[0] <= mem_f(c_mem_a);
    c_pipe[1] <= c_pipe[0];
    c_pipe[2] <= c_pipe[1];
  end
  assign c_mem_rd = c_pipe[2];

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic set_idle();
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    dm_wmask = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset with both requests asserted: nothing may be granted meanwhile.
  task automatic do_reset();
    rst_n   = 1'b0;
    if_req  = 1'b1;
    dm_req  = 1'b1;
    dm_we   = 1'b1;
    dm_wmask = 4'hF;
    @(negedge clk);
    chk("rst_if_gnt",    32'(a_if_gnt),    32'd0);
    chk("rst_dm_gnt",    32'(a_dm_gnt),    32'd0);
    chk("rst_mem_en",    32'(a_mem_en),    32'd0);
    chk("rst_mem_we",    32'(a_mem_we),    32'd0);
    chk("rst_mem_wmask", 32'(a_mem_wmask), 32'd0);
    chk("rst_if_rvalid", 32'(a_if_rvalid), 32'd0);
    chk("rst_dm_rvalid", 32'(a_dm_rvalid), 32'd0);
`ifdef MEMARB_PERF_CNT_EN
    chk("rst_perf_conflict", a_perf_conflict, 32'd0);
    chk("rst_perf_forced",   a_perf_forced,   32'd0);
`endif
    next_cycle();
    set_idle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wmask;
    logic        e_if_gnt;
    logic        e_dm_gnt;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_a;
    logic [3:0]  e_wmask;
    logic        e_if_rv;
    logic        e_dm_rv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [9];

  initial begin
    // in: if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wmask
    // exp: if_gnt, dm_gnt, en, we, a, wmask, if_rvalid, dm_rvalid, rdata
    tbl[0] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,        4'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0,
               1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 4'h0, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,        4'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'h0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h20, 32'h11223344, 4'h3,
               1'b0, 1'b1, 1'b1, 1'b1, 32'h20,  4'h3, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,        4'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h40, 32'h0,        4'h0,
               1'b0, 1'b1, 1'b1, 1'b0, 32'h40,  4'h0, 1'b0, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h44, 32'h0,        4'hF,
               1'b0, 1'b1, 1'b1, 1'b0, 32'h44,  4'h0, 1'b0, 1'b1, 32'h5A5A0040};
    tbl[7] = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0,
               1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 4'h0, 1'b0, 1'b1, 32'h5A5A0044};
    tbl[8] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,        4'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'h0, 1'b1, 1'b0, 32'h5A5A0200};

    set_idle();
    rst_n = 1'b0;
    next_cycle();
    do_reset();

    // ---------- table-driven vectors on u1 (RD_LAT=1) ----------
    for (int i = 0; i < 9; i++) begin
      if_req   = tbl[i].if_req;
      if_addr  = tbl[i].if_addr;
      dm_req   = tbl[i].dm_req;
      dm_we    = tbl[i].dm_we;
      dm_addr  = tbl[i].dm_addr;
      dm_wdata = tbl[i].dm_wdata;
      dm_wmask = tbl[i].dm_wmask;
      @(negedge clk);
      chk($sformatf("v%0d_if_gnt", i),    32'(a_if_gnt),    32'(tbl[i].e_if_gnt));
      chk($sformatf("v%0d_dm_gnt", i),    32'(a_dm_gnt),    32'(tbl[i].e_dm_gnt));
      chk($sformatf("v%0d_mem_en", i),    32'(a_mem_en),    32'(tbl[i].e_en));
      chk($sformatf("v%0d_mem_we", i),    32'(a_mem_we),    32'(tbl[i].e_we));
      chk($sformatf("v%0d_mem_wmask", i), 32'(a_mem_wmask), 32'(tbl[i].e_wmask));
      chk($sformatf("v%0d_if_rvalid", i), 32'(a_if_rvalid), 32'(tbl[i].e_if_rv));
      chk($sformatf("v%0d_dm_rvalid", i), 32'(a_dm_rvalid), 32'(tbl[i].e_dm_rv));
      if (tbl[i].e_en)
        chk($sformatf("v%0d_mem_a", i), a_mem_a, tbl[i].e_a);
      if (tbl[i].e_we)
        chk($sformatf("v%0d_mem_wd", i), a_mem_wd, tbl[i].dm_wdata);
      if (tbl[i].e_if_rv)
        chk($sformatf("v%0d_if_rdata", i), a_if_rdata, tbl[i].e_rdata);
      if (tbl[i].e_dm_rv)
        chk($sformatf("v%0d_dm_rdata", i), a_dm_rdata, tbl[i].e_rdata);
      next_cycle();
    end

    // ---------- starvation: 10 cycles of both requests on u1 ----------
    // MAX_WAIT=3: fetch forced through in cycles 3 and 7.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if_req  = 1'b1;
      if_addr = 32'h300;
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 32'h80;
      @(negedge clk);
      chk($sformatf("starve_c%0d_if_gnt", c), 32'(a_if_gnt),
          ((c == 3) || (c == 7)) ? 32'd1 : 32'd0);
      chk($sformatf("starve_c%0d_dm_gnt", c), 32'(a_dm_gnt),
          ((c == 3) || (c == 7)) ? 32'd0 : 32'd1);
      chk($sformatf("starve_c%0d_mem_a", c), a_mem_a,
          ((c == 3) || (c == 7)) ? 32'h300 : 32'h80);
      next_cycle();
    end
    set_idle();
    @(negedge clk);
`ifdef MEMARB_PERF_CNT_EN
    chk("perf_conflict", a_perf_conflict, 32'd10);
    chk("perf_forced",   a_perf_forced,   32'd2);
`endif
    next_cycle();

    // ---------- RD_LAT=3 interleaved reads on u3 ----------
    do_reset();
    for (int c = 0; c < 7; c++) begin
      set_idle();
      if (c == 0) begin if_req = 1'b1; if_addr = 32'h500; end
      if (c == 1) begin dm_req = 1'b1; dm_addr = 32'h600; end
      if (c == 2) begin if_req = 1'b1; if_addr = 32'h700; end
      @(negedge clk);
      chk($sformatf("lat3_c%0d_if_gnt", c), 32'(c_if_gnt),
          ((c == 0) || (c == 2)) ? 32'd1 : 32'd0);
      chk($sformatf("lat3_c%0d_dm_gnt", c), 32'(c_dm_gnt),
          (c == 1) ? 32'd1 : 32'd0);
      chk($sformatf("lat3_c%0d_if_rvalid", c), 32'(c_if_rvalid),
          ((c == 3) || (c == 5)) ? 32'd1 : 32'd0);
      chk($sformatf("lat3_c%0d_dm_rvalid", c), 32'(c_dm_rvalid),
          (c == 4) ? 32'd1 : 32'd0);
      if (c == 3) chk("lat3_c3_if_rdata", c_if_rdata, 32'h5A5A0500);
      if (c == 4) chk("lat3_c4_dm_rdata", c_dm_rdata, 32'h5A5A0600);
      if (c == 5) chk("lat3_c5_if_rdata", c_if_rdata, 32'h5A5A0700);
      next_cycle();
    end

    // ---------- reset one cycle after a load grant on u2 (RD_LAT=2) ----------
    do_reset();
    dm_req  = 1'b1;
    dm_addr = 32'h900;
    @(negedge clk);
    chk("rstmid_load_gnt", 32'(b_dm_gnt), 32'd1);
    next_cycle();
    rst_n  = 1'b0;
    if_req = 1'b1;
    dm_we  = 1'b1;
    dm_wmask = 4'hF;
    @(negedge clk);
    chk("rstmid_if_gnt",    32'(b_if_gnt),    32'd0);
    chk("rstmid_dm_gnt",    32'(b_dm_gnt),    32'd0);
    chk("rstmid_mem_en",    32'(b_mem_en),    32'd0);
    chk("rstmid_mem_we",    32'(b_mem_we),    32'd0);
    chk("rstmid_mem_wmask", 32'(b_mem_wmask), 32'd0);
    chk("rstmid_if_rvalid", 32'(b_if_rvalid), 32'd0);
    chk("rstmid_dm_rvalid", 32'(b_dm_rvalid), 32'd0);
    next_cycle();
    set_idle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid_after_c%0d_dm_rvalid", c), 32'(b_dm_rvalid), 32'd0);
      chk($sformatf("rstmid_after_c%0d_if_rvalid", c), 32'(b_if_rvalid), 32'd0);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
